// File: rtl/axi3_rd_mem_slave_pkg.sv
// AXI3 read responder: shared burst/resp encodings and FSM states.
// Imported by the interface, address generator and top.
package axi3_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_e;

    typedef enum logic {
        ST_IDLE,
        ST_BURST
    } rd_state_e;

    localparam int LEN_W  = 4;
    localparam int SIZE_W = 3;

    function automatic logic wrap_len_ok(logic [LEN_W-1:0] len);
        return len inside {4'd1, 4'd3, 4'd7, 4'd15};
    endfunction

endpackage

// File: rtl/axi3_rd_mem_slave_if.sv
// AXI3 address and read-data channel bundles.
// Master drives payload/valid, slave drives ready (A) or payload/valid (R).
interface AXI3_A_INTF #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32
);
    logic [ID_WIDTH-1:0]   aid;
    logic [ADDR_WIDTH-1:0] aaddr;
    logic [3:0]            alen;
    logic [2:0]            asize;
    logic [1:0]            aburst;
    logic                  avalid;
    logic                  aready;

    modport master (
        output aid, aaddr, alen, asize, aburst, avalid,
        input  aready
    );

    modport slave (
        input  aid, aaddr, alen, asize, aburst, avalid,
        output aready
    );
endinterface

interface AXI3_R_INTF #(
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 64
);
    logic [ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport master (
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi3_rd_mem_slave_addr_gen.sv
// Combinational next-beat address for FIXED/INCR/WRAP bursts.
// WRAP support only when AXI3_RD_MEM_SLAVE_WRAP_EN is defined.
module axi3_burst_addr_gen
    import axi3_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0] cur_addr,
    input  logic [SIZE_W-1:0]     size,
    input  logic [LEN_W-1:0]      len,
    input  logic [1:0]            burst,
    output logic [ADDR_WIDTH-1:0] next_addr,
    output logic                  wrap_err
);

    logic [ADDR_WIDTH-1:0] bsz;
    logic [ADDR_WIDTH-1:0] lo_mask;
    logic [ADDR_WIDTH-1:0] incr_addr;
    logic [ADDR_WIDTH-1:0] wrap_addr;

    assign bsz       = ADDR_WIDTH'(1) << size;
    assign lo_mask   = bsz - ADDR_WIDTH'(1);
    assign incr_addr = (cur_addr & ~lo_mask) + bsz;

`ifdef AXI3_RD_MEM_SLAVE_WRAP_EN
    logic [ADDR_WIDTH-1:0] win_mask;

    // Window is (len+1)*B bytes; only the low bits inside it advance.
    assign win_mask  = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size)
                       - ADDR_WIDTH'(1);
    assign wrap_addr = (cur_addr & ~win_mask)
                     | ((cur_addr + bsz) & win_mask);
    assign wrap_err  = (burst == BURST_WRAP)
                     && (!wrap_len_ok(len) || (|(cur_addr & lo_mask)));
`else
    logic unused_len;

    assign unused_len = ^len;
    assign wrap_addr  = cur_addr;
    assign wrap_err   = (burst == BURST_WRAP);
`endif

    always_comb begin
        next_addr = cur_addr;
        unique case (burst)
            BURST_FIXED: next_addr = cur_addr;
            BURST_INCR:  next_addr = incr_addr;
            BURST_WRAP:  next_addr = wrap_addr;
            default:     next_addr = cur_addr;
        endcase
    end

endmodule

// File: rtl/axi3_rd_mem_slave.sv
// AXI3 read-side memory responder, one burst at a time, 2-entry R buffer.
// WRAP bursts honoured only with AXI3_RD_MEM_SLAVE_WRAP_EN defined.
module axi3_rd_mem_slave
    import axi3_pkg::*;
#(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  aclk,
    input  logic                  areset_n,
    AXI3_A_INTF.slave             ar_if,
    AXI3_R_INTF.slave             r_if,
    output logic                  mem_ren,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_err
);

    localparam int MAX_SIZE = $clog2(DATA_WIDTH / 8);

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [DATA_WIDTH-1:0] data;
        logic [1:0]            resp;
        logic                  last;
    } r_beat_t;

    rd_state_e state_q, state_d;

    logic [ID_WIDTH-1:0]   id_q;
    logic [LEN_W-1:0]      len_q;
    logic [SIZE_W-1:0]     size_q;
    logic [1:0]            burst_q;
    logic                  err_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_W-1:0]      cnt_q;
    logic                  done_q;
    logic                  infl_q;
    logic                  infl_last_q;

    r_beat_t fifo_q [2];
    logic    wr_ptr_q;
    logic    rd_ptr_q;
    logic [1:0] count_q;

    logic [ADDR_WIDTH-1:0] g_addr;
    logic [SIZE_W-1:0]     g_size;
    logic [LEN_W-1:0]      g_len;
    logic [1:0]            g_burst;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic                  wrap_err;

    logic    ar_hs;
    logic    r_hs;
    logic    push;
    logic    pop;
    logic [1:0] occ;
    logic    issue;
    logic    acc_err;
    r_beat_t cap_beat;
    r_beat_t head;

    // In IDLE the generator sees the incoming AR so its wrap check can be latched.
    always_comb begin
        g_addr  = addr_q;
        g_size  = size_q;
        g_len   = len_q;
        g_burst = burst_q;
        if (state_q == ST_IDLE) begin
            g_addr  = ar_if.aaddr;
            g_size  = ar_if.asize;
            g_len   = ar_if.alen;
            g_burst = ar_if.aburst;
        end
    end

    axi3_burst_addr_gen #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_addr_gen (
        .cur_addr (g_addr),
        .size     (g_size),
        .len      (g_len),
        .burst    (g_burst),
        .next_addr(next_addr),
        .wrap_err (wrap_err)
    );

    assign ar_hs   = ar_if.avalid && ar_if.aready;
    assign r_hs    = r_if.rvalid && r_if.rready;
    assign pop     = r_hs;
    assign push    = infl_q;
    assign acc_err = (int'(ar_if.asize) > MAX_SIZE)
                   || (ar_if.aburst == BURST_RSVD)
                   || wrap_err;

    // Occupancy after this cycle's pop plus the beat still in the memory pipe.
    assign occ   = count_q - 2'(pop) + 2'(infl_q);
    assign issue = (state_q == ST_BURST) && !done_q && (occ < 2'd2);

    assign ar_if.aready = (state_q == ST_IDLE) && areset_n;
    assign mem_ren      = issue && !err_q;
    assign mem_addr     = addr_q;

    assign head        = fifo_q[rd_ptr_q];
    assign r_if.rvalid = (count_q != 2'd0);
    assign r_if.rid    = head.id;
    assign r_if.rdata  = head.data;
    assign r_if.rresp  = head.resp;
    assign r_if.rlast  = head.last;

    always_comb begin
        cap_beat.id   = id_q;
        cap_beat.data = err_q ? '0 : mem_rdata;
        cap_beat.resp = (err_q || mem_err) ? RESP_SLVERR : RESP_OKAY;
        cap_beat.last = infl_last_q;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (ar_hs) state_d = ST_BURST;
            ST_BURST: if (r_hs && r_if.rlast) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            state_q     <= ST_IDLE;
            id_q        <= '0;
            len_q       <= '0;
            size_q      <= '0;
            burst_q     <= '0;
            err_q       <= 1'b0;
            addr_q      <= '0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
            for (int i = 0; i < 2; i++) fifo_q[i] <= '0;
        end else begin
            state_q <= state_d;
            if (ar_hs) begin
                id_q    <= ar_if.aid;
                len_q   <= ar_if.alen;
                size_q  <= ar_if.asize;
                burst_q <= ar_if.aburst;
                err_q   <= acc_err;
                addr_q  <= ar_if.aaddr;
                cnt_q   <= '0;
                done_q  <= 1'b0;
            end else if (issue) begin
                addr_q <= next_addr;
                cnt_q  <= cnt_q + LEN_W'(1);
                if (cnt_q == len_q) done_q <= 1'b1;
            end
            infl_q      <= issue;
            infl_last_q <= issue && (cnt_q == len_q);
            if (push) begin
                fifo_q[wr_ptr_q] <= cap_beat;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_q + 2'(push) - 2'(pop);
        end
    end

endmodule

// File: doc/axi3_rd_mem_slave.md
# axi3_rd_mem_slave

AXI3 read-side responder that terminates the AR and R channels of an AXI3 master and services each burst from a simple synchronous memory port with 1-cycle read latency. It accepts one burst at a time and generates per-beat addresses for FIXED, INCR and WRAP bursts. Read data is returned through a 2-entry output buffer, which sustains one beat per cycle under R-channel backpressure. It sits in front of on-chip SRAM or register banks as the read endpoint of an AXI3 fabric.

## Interface
- ID_WIDTH, 4, AR/R ID width
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 64, data width; power of two, 8..1024
- aclk  in  1  clock
- areset_n  in  1  synchronous reset, active-low
- ar_if  AXI3_A_INTF.slave  (ID_WIDTH, ADDR_WIDTH)  read address channel
- r_if  AXI3_R_INTF.slave  (ID_WIDTH, DATA_WIDTH)  read data channel
- mem_ren  out  1  memory read strobe
- mem_addr  out  ADDR_WIDTH  byte address of the beat being read
- mem_rdata  in  DATA_WIDTH  read data, valid the cycle after mem_ren
- mem_err  in  1  error flag for the beat, valid with mem_rdata

## Operation
- States:
  - IDLE: aready=1.
    - On avalid&&aready, latch aid, aaddr, alen, asize and aburst, compute the error condition, then go to BURST.
  - BURST: aready=0. Issue len+1 beats.
    - Return to IDLE in the cycle after the R handshake of the beat with rlast=1.
- Error conditions (burst-wide; all len+1 beats get rresp=2'b10 SLVERR, rdata=0, and no mem_ren):
  - asize > log2(DATA_WIDTH/8)
  - aburst=2'b11
  - WRAP with alen not in {1,3,7,15}
  - WRAP with aaddr not aligned to asize
- Address generation, with beat size B = 1<<asize:
  - FIXED: every beat uses aaddr.
  - INCR: beat 0 uses aaddr; each later beat uses (previous address aligned down to B) + B, modulo 2^ADDR_WIDTH. 4 KB crossing is not checked.
  - WRAP: the wrap boundary is (alen+1)*B. The address increments by B, and the low bits wrap inside the boundary-aligned window.
- Beat issue: a beat issues when beats remain and (FIFO occupancy after this cycle's pop) + in-flight beats < 2. A good beat asserts mem_ren for one cycle. An error beat issues a bubble through the same 1-cycle pipeline slot.
- Capture: the cycle after issue, the FIFO captures {rid=latched aid, rdata=mem_rdata or 0, rresp=mem_err?2'b10:2'b00, rlast=(beat==alen)}.
- mem_err affects only its own beat. Other beats keep OKAY.
- r_if outputs are driven from the FIFO head; rvalid = FIFO not empty.

## Timing
- Reset (areset_n=0 at a clock edge), required output values:
  - aready=0, rvalid=0, mem_ren=0
  - rid/rdata/rresp/rlast=0
  - FIFO, in-flight flag and beat counter cleared
  - In the first cycle after reset is released: aready=1.
- Latency: AR handshake at cycle T; mem_ren at T+1; data captured at the end of T+2; rvalid at T+3.
- Throughput is 1 beat/cycle with rready held high. The next AR is accepted no earlier than the cycle after the last R handshake.
- Once rvalid is asserted, it and the FIFO-head payload are held stable until rready.
- Reset mid-burst: everything is discarded. A mem_rdata arriving in the cycle after reset is ignored.
- Simultaneous push and pop on the FIFO is allowed. Occupancy never exceeds 2.

## Configuration
- AXI3_RD_MEM_SLAVE_WRAP_EN defined: WRAP bursts are supported as above.
- Undefined: every WRAP burst is treated as an error burst (len+1 SLVERR beats, no mem_ren), and the wrap logic is not synthesized.

## Structure
- axi3_pkg: burst encodings (FIXED=2'b00, INCR=2'b01, WRAP=2'b10) and resp encodings (OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11).
- Sub-module axi3_burst_addr_gen (combinational): inputs are current address, size, len and burst; output is the next beat address. The WRAP_EN ifdef is localized in this sub-module.
- The 2-entry FIFO is inline.

## Test plan
- INCR, aaddr=0x100, alen=3, asize=3, rready=1:
  - mem_addr 0x100, 0x108, 0x110, 0x118 on consecutive cycles
  - 4 beats back-to-back, rlast on beat 3, first rvalid 3 cycles after the AR handshake
- WRAP, aaddr=0x38, alen=7, asize=3:
  - mem_addr 0x38, 0x00, 0x08 … 0x30
  - With the macro undefined: 8 SLVERR beats and no mem_ren.
- Backpressure: INCR alen=15 with rready toggling 1,0,0,1…:
  - No beat lost or duplicated; payload stable while stalled; mem_ren never issues with FIFO+in-flight ≥ 2.
- Error bursts, each returning alen+1 SLVERR beats with rid echoed and no mem_ren:
  - asize=4 with DATA_WIDTH=64
  - aburst=2'b11
- mem_err on beat 1 of a 4-beat INCR: rresp = OKAY, SLVERR, OKAY, OKAY.
- areset_n low during beat 2 of an 8-beat burst: next cycle rvalid=0 and aready=0; after release, a new AR is accepted and completes correctly; stale data never appears.
